// File: rtl/axil_palette_ram.sv
// axil_palette_ram: multi-palette colour RAM with an AXI-Lite programming port and a 2-cycle pixel lookup port.
// Define AXIL_PALETTE_BOUNDS_CHECK_EN to answer accesses above the table with SLVERR instead of aliasing.
module axil_palette_ram #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_PALETTES = 4,
    parameter int ENTRIES      = 256
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [ADDR_WIDTH-1:0]             s_axil_awaddr,
    input  logic [2:0]                        s_axil_awprot,
    input  logic                              s_axil_awvalid,
    output logic                              s_axil_awready,
    input  logic [DATA_WIDTH-1:0]             s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]           s_axil_wstrb,
    input  logic                              s_axil_wvalid,
    output logic                              s_axil_wready,
    output logic [1:0]                        s_axil_bresp,
    output logic                              s_axil_bvalid,
    input  logic                              s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]             s_axil_araddr,
    input  logic [2:0]                        s_axil_arprot,
    input  logic                              s_axil_arvalid,
    output logic                              s_axil_arready,
    output logic [DATA_WIDTH-1:0]             s_axil_rdata,
    output logic [1:0]                        s_axil_rresp,
    output logic                              s_axil_rvalid,
    input  logic                              s_axil_rready,
    input  logic                              px_valid,
    input  logic [$clog2(NUM_PALETTES)-1:0]   px_palette,
    input  logic [$clog2(ENTRIES)-1:0]        px_index,
    output logic                              col_valid,
    output logic [DATA_WIDTH-1:0]             col_data
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH      = NUM_PALETTES * ENTRIES;
    localparam int SB         = $clog2(STRB_WIDTH);
    localparam int AW         = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d;
    logic rd_pend_q, rd_pend_d, rvalid_q, rvalid_d, px_v_q, col_valid_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d, w_addr;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d, w_data, rdata_q, px_data_q, col_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d, w_strb;
    logic [1:0] bresp_q, bresp_d, rresp_q;
    logic aw_hs, w_hs, ar_hs, aw_have, w_have, commit, we, rd_fire, w_oob, r_oob;
    logic [AW-1:0] widx, ridx;
    logic unused_ok;

    assign s_axil_awready = !areset && !aw_held_q;
    assign s_axil_wready  = !areset && !w_held_q;
    assign s_axil_arready = !areset && !rd_pend_q && !rvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign col_valid      = col_valid_q;
    assign col_data       = col_data_q;

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign ar_hs   = s_axil_arvalid && s_axil_arready;
    // A beat arriving this cycle counts as held, so a paired AW/W commits on its handshake edge.
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q || w_hs;
    assign commit  = !areset && aw_have && w_have && (!bvalid_q || s_axil_bready);
    assign w_addr  = aw_held_q ? aw_addr_q : s_axil_awaddr;
    assign w_data  = w_held_q ? w_data_q : s_axil_wdata;
    assign w_strb  = w_held_q ? w_strb_q : s_axil_wstrb;
    assign widx    = w_addr[SB +: AW];
    assign ridx    = ar_addr_q[SB +: AW];
    assign we      = commit && !w_oob;
    assign rd_fire = rd_pend_q && !commit;

`ifdef AXIL_PALETTE_BOUNDS_CHECK_EN
    assign w_oob = |w_addr[ADDR_WIDTH-1:SB+AW];
    assign r_oob = |ar_addr_q[ADDR_WIDTH-1:SB+AW];
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, w_addr, ar_addr_q};

    assign aw_held_d = aw_have && !commit;
    assign w_held_d  = w_have && !commit;
    assign aw_addr_d = aw_hs ? s_axil_awaddr : aw_addr_q;
    assign w_data_d  = w_hs ? s_axil_wdata : w_data_q;
    assign w_strb_d  = w_hs ? s_axil_wstrb : w_strb_q;
    assign bvalid_d  = commit || (bvalid_q && !s_axil_bready);
    assign bresp_d   = commit ? (w_oob ? 2'b10 : 2'b00) : bresp_q;
    assign ar_addr_d = ar_hs ? s_axil_araddr : ar_addr_q;
    assign rd_pend_d = ar_hs || (rd_pend_q && commit);
    assign rvalid_d  = rd_fire || (rvalid_q && !s_axil_rready);

    always_ff @(posedge aclk) begin
        if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++)
                if (w_strb[b]) mem_q[widx][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            ar_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            px_v_q      <= 1'b0;
            px_data_q   <= '0;
            col_valid_q <= 1'b0;
            col_data_q  <= '0;
        end else begin
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            ar_addr_q   <= ar_addr_d;
            rd_pend_q   <= rd_pend_d;
            rvalid_q    <= rvalid_d;
            if (rd_fire) begin
                rdata_q <= r_oob ? '0 : mem_q[ridx];
                rresp_q <= r_oob ? 2'b10 : 2'b00;
            end
            // Pixel port reads on the request edge, so a same-cycle write is not yet visible.
            px_v_q      <= px_valid;
            px_data_q   <= mem_q[{px_palette, px_index}];
            col_valid_q <= px_v_q;
            col_data_q  <= px_data_q;
        end
    end
endmodule
